// File: rtl/stream_reader.sv
// Streaming memory reader: issues sequential word reads under a credit limit
// and forwards in-order returns through a small buffer to a fifo write port.
module stream_reader #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [LEN_WIDTH-1:0]  lenIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic                  memReqOut,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  input  logic                  memReadyIn,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  input  logic                  memValidIn,
  output logic [DATA_WIDTH-1:0] wrDataOut,
  output logic                  wrValidOut,
  input  logic                  wrReadyIn
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W:0]        MAX_CREDIT = (CNT_W + 1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [LEN_WIDTH-1:0]  reqRemain;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  doneReg;
  logic                  quiet;
  logic [DATA_WIDTH-1:0] buffer [MAX_OUTSTANDING];

  logic           accept;
  logic           push;
  logic           pop;
  logic [CNT_W:0] inFlight;

  // Credit uses registered counts only, so a pop frees its slot one cycle later.
  assign inFlight   = {1'b0, outstanding} + {1'b0, count};
  assign memReqOut  = (state == RUN) && (reqRemain != '0) && (inFlight < MAX_CREDIT);
  assign memAddrOut = addrReg;
  assign accept     = memReqOut && memReadyIn;
  assign push       = memValidIn && (outstanding != '0);
  assign wrValidOut = (count != '0);
  assign wrDataOut  = wrValidOut ? buffer[rdPtr] : '0;
  assign pop        = wrValidOut && wrReadyIn;
  assign busyOut    = (state != IDLE);
  assign doneOut    = doneReg;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state       <= IDLE;
      addrReg     <= '0;
      reqRemain   <= '0;
      outstanding <= '0;
      count       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      doneReg     <= 1'b0;
      quiet       <= 1'b1;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (startIn) begin
            if (lenIn != '0) begin
              state     <= RUN;
              addrReg   <= addrIn;
              reqRemain <= lenIn;
              quiet     <= 1'b0;
            end else begin
              doneReg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            addrReg   <= addrReg + ADDR_STEP;
            reqRemain <= reqRemain - LEN_ONE;
            if (reqRemain == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((outstanding == '0) && (count == '0)) begin
            state   <= IDLE;
            doneReg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept && !push) begin
        outstanding <= outstanding + CNT_ONE;
      end else if (!accept && push) begin
        outstanding <= outstanding - CNT_ONE;
      end

      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end

      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (push) begin
      buffer[wrPtr] <= memDataIn;
    end
  end

  // Returns after a reset abort are expected and silently dropped until the next start.
  assert property (@(posedge clkIn) disable iff (!rstIn)
                   !(memValidIn && (outstanding == '0) && !quiet))
    else $error("stream_reader: read return with no outstanding request");

endmodule

// File: doc/stream_reader.md
STREAM_READER -- requirements
Module: stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the stream and memory data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the byte address width.
REQ-003 The block SHALL have parameter LEN_WIDTH, default 16, giving the transfer length width in words.
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 4, giving both the in-flight read limit and the internal buffer depth (power of two, at least 2).
REQ-005 The block SHALL have port clkIn, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rstIn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port startIn, input, 1 bit: start pulse, sampled only in IDLE.
REQ-008 The block SHALL have port addrIn, input, ADDR_WIDTH bits: start byte address, captured on accepted start.
REQ-009 The block SHALL have port lenIn, input, LEN_WIDTH bits: transfer length in words, captured on accepted start.
REQ-010 The block SHALL have port busyOut, output, 1 bit: high in RUN or DRAIN.
REQ-011 The block SHALL have port doneOut, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port memReqOut, output, 1 bit: memory read request valid.
REQ-013 The block SHALL have port memAddrOut, output, ADDR_WIDTH bits: memory read byte address.
REQ-014 The block SHALL have port memReadyIn, input, 1 bit: memory accepts the request this cycle.
REQ-015 The block SHALL have port memDataIn, input, DATA_WIDTH bits: read return data, in order.
REQ-016 The block SHALL have port memValidIn, input, 1 bit: read return valid (no backpressure).
REQ-017 The block SHALL have port wrDataOut, output, DATA_WIDTH bits: stream data to a fifo write port.
REQ-018 The block SHALL have port wrValidOut, output, 1 bit: stream valid.
REQ-019 The block SHALL have port wrReadyIn, input, 1 bit: stream ready from the fifo.

Function
REQ-020 The block SHALL implement states IDLE, RUN and DRAIN.
- IDLE->RUN: startIn=1 and lenIn!=0.
- RUN->DRAIN: the cycle the last request is accepted.
- DRAIN->IDLE: outstanding=0, buffer empty, no pop pending.
REQ-021 If startIn=1 with lenIn=0 in IDLE, the block SHALL pulse doneOut on the next cycle and remain in IDLE.
REQ-022 The block SHALL ignore startIn while busyOut=1.
REQ-023 A request SHALL be accepted when memReqOut=1 and memReadyIn=1; memReqOut and memAddrOut SHALL hold stable until accepted.
REQ-024 The block SHALL assert memReqOut only in RUN, with requests remaining, and with (outstanding + buffered words) < MAX_OUTSTANDING.
REQ-025 The credit check SHALL use registered counts only; a same-cycle pop SHALL NOT free a credit until the next cycle.
REQ-026 memAddrOut SHALL equal the captured addrIn for the first request and SHALL increase by DATA_WIDTH/8 after each accepted request, wrapping modulo 2^ADDR_WIDTH.
REQ-027 The first memReqOut SHALL assert the cycle after the start is accepted.
REQ-028 The outstanding counter SHALL increment on accept, decrement on memValidIn, and stay unchanged when both occur in the same cycle.
REQ-029 memValidIn=1 SHALL write memDataIn into the internal buffer tail; the buffer SHALL never overflow, by construction of REQ-024.
REQ-030 wrValidOut SHALL be high exactly when the buffer is non-empty, and wrDataOut SHALL present the buffer head.
REQ-031 Data SHALL be popped when wrValidOut=1 and wrReadyIn=1; data returned in cycle k SHALL be visible on wrValidOut at cycle k+1.
REQ-032 Simultaneous push and pop SHALL leave the buffer count unchanged.
REQ-033 Exactly lenIn words SHALL be emitted, in address order, with no loss or duplication under any wrReadyIn pattern.
REQ-034 doneOut SHALL pulse for one cycle on the DRAIN->IDLE transition, and busyOut SHALL fall in that same cycle.
REQ-035 memValidIn with outstanding=0 SHALL raise a simulation $error and SHALL be otherwise ignored.

Reset
REQ-036 While rstIn=0, the block SHALL asynchronously clear state to IDLE and zero all counters and pointers.
REQ-037 While rstIn=0, busyOut, doneOut, memReqOut and wrValidOut SHALL be 0, and memAddrOut and wrDataOut SHALL be 0.
REQ-038 Reset mid-transfer SHALL abort the transfer, discard buffered data, and ignore late memValidIn returns until a new start (no $error while in IDLE after reset).

Verification
REQ-039 Basic: addr=0x100, len=3, memReadyIn=1, latency 2, wrReadyIn=1 -> addresses 0x100/0x104/0x108, words emitted in order, doneOut single pulse, busyOut low after.
REQ-040 Backpressure: len=8, wrReadyIn=0 -> exactly 4 requests issued, then none; releasing wrReadyIn completes all 8 words in order.
REQ-041 Zero length: start with len=0 -> doneOut pulses next cycle, memReqOut never asserted.
REQ-042 Wrap: addr=0xFFFFFFFC, len=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-043 Stall and ignore: memReadyIn random with 50% duty plus a second startIn mid-transfer -> memAddrOut stable while stalled, second start ignored, data matches the model.
REQ-044 Reset: rstIn asserted low with 2 reads outstanding -> outputs are 0 immediately; late returns produce no wrValidOut; a following len=1 start completes normally.
